aes_iter_cipher: RTL and testbench
==================================

Name: aes_iter_cipher

Overview:
Iterative AES encryption core, one round per clock, with on-the-fly key expansion and valid/ready handshakes on both input and output. It is generalised over key length: AES-128 (10 rounds) or AES-256 (14 rounds). It sits between a block-feeding front end and a ciphertext consumer and replaces the fixed-key, free-running round engine.

Parameters:
KEY_BITS, 128, key length; legal values 128 or 256; any other value -> $fatal at elaboration
NR, derived (10 or 14), round count; localparam, not overridable

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  plaintext/key offer
in_ready  out  1  core can accept; high only in IDLE
in_block  in  128  plaintext; [127:120] = byte 0, column-major per FIPS-197
in_key  in  KEY_BITS  cipher key; MSB byte = key byte 0
out_valid  out  1  ciphertext available
out_ready  in  1  consumer accepts ciphertext
out_block  out  128  ciphertext; same byte order as in_block
busy  out  1  high in RUN or DONE
round_o  out  4  current round number; 0 in IDLE

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; round=0; state/key registers=0; out_valid=0; out_block=0; busy=0; in_ready=1 after reset. Reset mid-RUN or mid-DONE aborts with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid at posedge, the core accepts and:
  - AES-128: st <= in_block ^ in_key; kA <= in_key.
  - AES-256: st <= in_block ^ in_key[255:128]; kA <= in_key[255:128]; kB <= in_key[127:0].
  - Sets round <= 1 and goes to RUN.
- RUN: one round per cycle, round r = 1..NR.
  - Rounds 1..NR-1: st <= MixColumns(ShiftRows(SubBytes(st))) ^ rk.
  - Round NR: MixColumns is omitted.
  - AES-128 round key: rk = expand128(kA, RCON[r]), and kA <= rk.
  - AES-256 round key: rk = kB. kA <= kB. kB <= expand256(kA, kB, r):
    - r odd: RotWord+SubWord+RCON[(r+1)/2] on the last word of kB.
    - r even: SubWord only, no Rot, no Rcon.
    - Each word of the new kB = corresponding word of kA ^ the running previous word.
  - RCON = 01,02,04,08,10,20,40,80,1b,36.
  - After round NR: round <= 0, state goes to DONE, out_block <= final st, out_valid <= 1.
- Latency: accept at edge T -> out_valid high after edge T+NR (10 or 14 cycles).
- Throughput: one block per NR+2 cycles minimum. No overlap between blocks.
- DONE:
  - out_valid=1; out_block held stable until handshake.
  - out_valid & out_ready at posedge -> IDLE, out_valid <= 0.
  - in_valid in RUN or DONE is ignored (in_ready=0), and in_block/in_key changes have no effect.
  - out_ready in IDLE or RUN has no effect.
- in_ready and busy are decoded from the state register only, with no combinational path from in_valid or out_ready.
- round_o = round register: 1..NR during RUN, 0 in IDLE and DONE.
- out_block keeps its last value after the handshake until the next completion.

Decomposition:
- Package aes_pkg holds:
  - state_e typedef (IDLE/RUN/DONE).
  - sbox, xtime, mixcol, shiftrows, subbytes functions.
  - RCON constant array.
  - nr_for(key_bits) function.
- Sub-module aes_key_step: purely combinational next-round-key generator.
  - Inputs: kA, kB, r, and a mode bit.
  - Output: next key word set.
  - Instantiated once; the 128-bit mode ignores kB.

Test Plan:
1. KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_block 3925841d02dc09fbdc118597196a0b32; out_valid exactly 10 cycles after accept.
2. KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
3. KEY_BITS=256, key 000102...1e1f, pt 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089; latency 14; round_o steps 1..14.
4. Back-pressure: out_ready=0 for 20 cycles after completion -> out_valid and out_block stable, in_ready=0 and a new in_valid is ignored. Then out_ready=1 for one cycle -> IDLE, in_ready=1 next cycle.
5. Reset mid-RUN: assert rst_n=0 at round 5 -> next cycle out_valid=0, out_block=0, round_o=0, in_ready=1. A following vector-1 run still yields 3925841d...0b32.
6. Back-to-back: three vectors offered with in_valid held high -> each accepted only in IDLE, with correct ciphertexts in order. Changing in_key during RUN does not alter the result.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types and round primitives: state encoding, S-box, ShiftRows/MixColumns and Rcon.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic int nr_for(input int key_bits);
        return (key_bits == 256) ? 14 : 10;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 (zero maps to zero), then the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] subbytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte i sits at [127-8i -: 8]; column c = i/4, row r = i%4.
    function automatic logic [127:0] shiftrows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mixcol(s[127-32*c -: 32]);
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// Combinational next-round-key step: AES-128 expands ka; AES-256 builds the next kb from ka and kb.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] ka,
    input  logic [127:0] kb,
    input  logic [3:0]   round,
    input  logic         mode,
    output logic [127:0] key_next
);

    logic [3:0]  ridx;
    logic [7:0]  rcon;
    logic [31:0] last;
    logic [31:0] t;
    logic [31:0] w0, w1, w2, w3;

    always_comb begin
        // AES-256 consumes one Rcon per pair of rounds.
        ridx = mode ? ((round + 4'd1) >> 1) : round;
        rcon = (ridx >= 4'd1 && ridx <= 4'd10) ? RCON[ridx - 4'd1] : 8'h00;
        last = mode ? kb[31:0] : ka[31:0];
        if (mode && !round[0])
            t = subword(last);
        else
            t = subword({last[23:0], last[31:24]}) ^ {rcon, 24'h000000};
        w0 = ka[127:96] ^ t;
        w1 = ka[95:64]  ^ w0;
        w2 = ka[63:32]  ^ w1;
        w3 = ka[31:0]   ^ w2;
        key_next = {w0, w1, w2, w3};
    end

endmodule

// File: rtl/aes_iter_cipher.sv
// Iterative AES-128/256 encryptor, one round per clock; out_valid rises NR edges after accept.
// Single block in flight: in_ready only in IDLE, result held in DONE until out_ready.
module aes_iter_cipher
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_block,
    input  logic [KEY_BITS-1:0] in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_block,
    output logic                busy,
    output logic [3:0]          round_o
);

    localparam int         NR         = nr_for(KEY_BITS);
    localparam logic [3:0] LAST_ROUND = 4'(NR);
    localparam logic       IS256      = (KEY_BITS == 256);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
            $fatal(1, "aes_iter_cipher: KEY_BITS must be 128 or 256");
        end
    endgenerate

    state_e       state;
    state_e       state_next;
    logic [127:0] st;
    logic [127:0] ka;
    logic [127:0] kb;
    logic [3:0]   round;
    logic [127:0] key_next;
    logic [127:0] rk;
    logic [127:0] sr;
    logic [127:0] round_out;
    logic         last_round;

    aes_key_step u_key_step (
        .ka       (ka),
        .kb       (kb),
        .round    (round),
        .mode     (IS256),
        .key_next (key_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (last_round) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        last_round = (round == LAST_ROUND);
        rk         = IS256 ? kb : key_next;
        sr         = shiftrows(subbytes(st));
        round_out  = (last_round ? sr : mixcolumns(sr)) ^ rk;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= '0;
            ka        <= '0;
            kb        <= '0;
            round     <= 4'd0;
            out_block <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    st    <= in_block ^ in_key[KEY_BITS-1 -: 128];
                    ka    <= in_key[KEY_BITS-1 -: 128];
                    kb    <= IS256 ? in_key[127:0] : '0;
                    round <= 4'd1;
                end
                RUN: begin
                    st <= round_out;
                    // AES-256 round keys slide through kb -> ka; AES-128 keeps only ka.
                    ka <= IS256 ? kb : key_next;
                    kb <= IS256 ? key_next : '0;
                    if (last_round) begin
                        round     <= 4'd0;
                        out_block <= round_out;
                        out_valid <= 1'b1;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign round_o  = round;

endmodule

// File: tb/tb_aes_iter_cipher.sv
// Bench for aes_iter_cipher: one AES-128 and one AES-256 instance against known-answer vectors.
module tb_aes_iter_cipher;

    typedef struct {
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        int           is256;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   in_valid;
    logic [1:0]   out_ready;
    logic [127:0] in_block [2];
    logic [127:0] key128;
    logic [255:0] key256;
    wire  [1:0]   in_ready;
    wire  [1:0]   out_valid;
    wire  [1:0]   busy;
    wire  [127:0] out_block [2];
    wire  [3:0]   round_o [2];

    vec_t         tbl [5];
    int           b2b [3] = '{0, 1, 3};
    logic [127:0] q0 [$];
    logic [127:0] q1 [$];
    logic [127:0] exp0;
    logic [127:0] exp1;
    int           n_chk  = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    aes_iter_cipher #(.KEY_BITS(128)) dut128 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_block(in_block[0]), .in_key(key128),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_block(out_block[0]), .busy(busy[0]), .round_o(round_o[0])
    );

    aes_iter_cipher #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_block(in_block[1]), .in_key(key256),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_block(out_block[1]), .busy(busy[1]), .round_o(round_o[1])
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bounded wait expired", name);
    endtask

    // Scoreboard: every completed output handshake pops the oldest expected ciphertext.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid[0] === 1'b1 && out_ready[0] === 1'b1) begin
            if (q0.size() == 0) fail_now("ct128 unexpected output");
            else begin
                exp0 = q0.pop_front();
                check("ct128", out_block[0], exp0);
            end
        end
        if (rst_n === 1'b1 && out_valid[1] === 1'b1 && out_ready[1] === 1'b1) begin
            if (q1.size() == 0) fail_now("ct256 unexpected output");
            else begin
                exp1 = q1.pop_front();
                check("ct256", out_block[1], exp1);
            end
        end
    end

    task automatic wait_ready(input int d);
        int n;
        n = 0;
        while (in_ready[d] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) fail_now($sformatf("wait in_ready dut%0d", d));
    endtask

    task automatic offer(input int d, input int i);
        wait_ready(d);
        in_valid[d] = 1'b1;
        in_block[d] = tbl[i].pt;
        if (d == 1) begin
            key256 = tbl[i].key;
            q1.push_back(tbl[i].ct);
        end else begin
            key128 = tbl[i].key[127:0];
            q0.push_back(tbl[i].ct);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input int i);
        int d;
        int n;
        int nr;
        d  = tbl[i].is256;
        nr = (d == 1) ? 14 : 10;
        offer(d, i);
        in_valid[d] = 1'b0;
        in_block[d] = {$urandom, $urandom, $urandom, $urandom};
        key128      = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        while (out_valid[d] !== 1'b1 && n < 40) begin
            check($sformatf("v%0d round_o", i), 128'(round_o[d]), 128'(n + 1));
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("v%0d latency", i), 128'(n), 128'(nr));
        check($sformatf("v%0d done in_ready", i), 128'(in_ready[d]), 128'(0));
        check($sformatf("v%0d done busy", i), 128'(busy[d]), 128'(1));
        check($sformatf("v%0d done round_o", i), 128'(round_o[d]), 128'(0));
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
        check($sformatf("v%0d post out_valid", i), 128'(out_valid[d]), 128'(0));
        check($sformatf("v%0d post in_ready", i), 128'(in_ready[d]), 128'(1));
        check($sformatf("v%0d post busy", i), 128'(busy[d]), 128'(0));
        check($sformatf("v%0d out_block held", i), out_block[d], tbl[i].ct);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0] = '{256'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                   128'h3925841d02dc09fbdc118597196a0b32, 0};
        tbl[1] = '{256'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0};
        tbl[2] = '{256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                   128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 1};
        tbl[3] = '{256'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
                   128'h3ad77bb40d7a3660a89ecaf32466ef97, 0};
        tbl[4] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                   128'h6bc1bee22e409f96e93d7e117393172a, 128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 1};

        rst_n       = 1'b0;
        in_valid    = 2'b00;
        out_ready   = 2'b00;
        in_block[0] = '0;
        in_block[1] = '0;
        key128      = '0;
        key256      = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset in_ready%0d", d), 128'(in_ready[d]), 128'(1));
            check($sformatf("reset out_valid%0d", d), 128'(out_valid[d]), 128'(0));
            check($sformatf("reset busy%0d", d), 128'(busy[d]), 128'(0));
            check($sformatf("reset round_o%0d", d), 128'(round_o[d]), 128'(0));
            check($sformatf("reset out_block%0d", d), out_block[d], 128'(0));
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) run_vec(i);

        // Back-pressure: result must hold for 20 cycles while a new offer is ignored.
        offer(0, 0);
        in_valid[0] = 1'b0;
        n = 0;
        while (out_valid[0] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) fail_now("bp wait out_valid");
        in_valid[0] = 1'b1;
        in_block[0] = tbl[1].pt;
        key128      = tbl[1].key[127:0];
        for (int c = 0; c < 20; c++) begin
            check("bp out_valid", 128'(out_valid[0]), 128'(1));
            check("bp out_block", out_block[0], tbl[0].ct);
            check("bp in_ready", 128'(in_ready[0]), 128'(0));
            @(posedge clk); #1;
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        check("bp release out_valid", 128'(out_valid[0]), 128'(0));
        check("bp release in_ready", 128'(in_ready[0]), 128'(1));
        @(posedge clk); #1;
        check("bp idle in_ready", 128'(in_ready[0]), 128'(1));
        check("bp idle busy", 128'(busy[0]), 128'(0));

        // Reset at round 5 aborts the block with no output.
        offer(0, 0);
        in_valid[0] = 1'b0;
        n = 0;
        while (round_o[0] !== 4'd5 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) fail_now("rst wait round 5");
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst out_valid", 128'(out_valid[0]), 128'(0));
        check("rst out_block", out_block[0], 128'(0));
        check("rst round_o", 128'(round_o[0]), 128'(0));
        check("rst in_ready", 128'(in_ready[0]), 128'(1));
        void'(q0.pop_back());
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(0);

        // Back-to-back with in_valid held; key/block scrambled while each block runs.
        out_ready[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            offer(0, b2b[k]);
            check($sformatf("b2b%0d accepted", k), 128'(in_ready[0]), 128'(0));
            in_block[0] = {$urandom, $urandom, $urandom, $urandom};
            key128      = {$urandom, $urandom, $urandom, $urandom};
        end
        wait_ready(0);
        in_valid[0]  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        check("b2b idle busy", 128'(busy[0]), 128'(0));
        check("q0 drained", 128'(q0.size()), 128'(0));
        check("q1 drained", 128'(q1.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
